// File: rtl/axis_pkt_fifo_pkg.sv
// Shared constants and helpers for the AXI-Stream packet FIFO.
package axis_pkg;

    // Default distance of the almost-full threshold below the full level
    localparam int DEF_AF_MARGIN = 4;

    // Default level at or below which the FIFO reports almost-empty
    localparam int DEF_AE_THR = 4;

    // Width needed to hold an entry count from 0 up to and including depth
    function automatic int levelWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream bundle with master and slave views.
interface axis_pkt_fifo_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_pkt_fifo_mem.sv
// Storage array for the packet FIFO: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]         i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [WIDTH-1:0]         o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Capture the incoming word; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward gating on tlast.
// Output is fall-through: the head entry is visible on m_axis without a
// read cycle. In packet mode the output is held back until a complete
// packet is stored, unless the FIFO fills with no packet boundary inside,
// in which case a release flag lets data drain until a tlast word leaves.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 64,
    parameter int PACKET_MODE      = 1,
    parameter int ALMOST_FULL_THR  = FIFO_DEPTH - DEF_AF_MARGIN,
    parameter int ALMOST_EMPTY_THR = DEF_AE_THR
) (
    input  logic                                clk_i,
    input  logic                                arstn_i,
    axis_pkt_fifo_if.slave                      s_axis,
    axis_pkt_fifo_if.master                     m_axis,
    output logic [levelWidth(FIFO_DEPTH)-1:0]   level_o,
    output logic                                almost_full_o,
    output logic                                almost_empty_o,
    output logic [levelWidth(FIFO_DEPTH)-1:0]   pkt_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = levelWidth(FIFO_DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AF_THR  = LW'(ALMOST_FULL_THR);
    localparam logic [LW-1:0] AE_THR  = LW'(ALMOST_EMPTY_THR);

    logic [AW:0]         r_wrPtr;
    logic [AW:0]         r_rdPtr;
    logic [LW-1:0]       r_level;
    logic [LW-1:0]       r_pktCnt;
    logic                r_release;
    logic                r_almostFull;
    logic                r_almostEmpty;

    logic [LW-1:0]       w_levelNext;
    logic [LW-1:0]       w_pktNext;
    logic                w_releaseNext;
    logic                w_full;
    logic                w_empty;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_pushLast;
    logic                w_popLast;
    logic [DATA_WIDTH:0] w_wrData;
    logic [DATA_WIDTH:0] w_rdData;

    assign w_full  = (r_level == DEPTH_L);
    assign w_empty = (r_level == '0);

    // Cut-through ignores packet boundaries; packet mode needs a stored
    // packet or the deadlock-escape release before presenting data
    assign w_valid = ~w_empty & ((PACKET_MODE == 0) | (r_pktCnt != '0) | r_release);

    assign w_push     = s_axis.tvalid & ~w_full;
    assign w_pop      = w_valid & m_axis.tready;
    assign w_pushLast = w_push & s_axis.tlast;
    assign w_popLast  = w_pop & w_rdData[DATA_WIDTH];
    assign w_wrData   = {s_axis.tlast, s_axis.tdata};

    assign s_axis.tready  = ~w_full;
    assign m_axis.tvalid  = w_valid;
    assign m_axis.tdata   = w_rdData[DATA_WIDTH-1:0];
    assign m_axis.tlast   = w_rdData[DATA_WIDTH];
    assign level_o        = r_level;
    assign pkt_cnt_o      = r_pktCnt;
    assign almost_full_o  = r_almostFull;
    assign almost_empty_o = r_almostEmpty;

    // Next-state occupancy, packet count and release flag
    always_comb begin
        w_levelNext   = r_level;
        w_pktNext     = r_pktCnt;
        w_releaseNext = r_release;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - LW'(1);
        end
        if (w_pushLast && !w_popLast) begin
            w_pktNext = r_pktCnt + LW'(1);
        end else if (!w_pushLast && w_popLast) begin
            w_pktNext = r_pktCnt - LW'(1);
        end
        if (w_popLast) begin
            w_releaseNext = 1'b0;
        end
        if ((PACKET_MODE != 0) && (w_levelNext == DEPTH_L) && (w_pktNext == '0)) begin
            w_releaseNext = 1'b1;
        end
    end

    // Pointer, counter and flag registers; stored data is left untouched by reset
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_level       <= '0;
            r_pktCnt      <= '0;
            r_release     <= 1'b0;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
            r_level       <= w_levelNext;
            r_pktCnt      <= w_pktNext;
            r_release     <= w_releaseNext;
            r_almostFull  <= (w_levelNext >= AF_THR);
            r_almostEmpty <= (w_levelNext <= AE_THR);
        end
    end

    fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk_i    (clk_i),
        .i_wrEn   (w_push),
        .i_wrAddr (r_wrPtr[AW-1:0]),
        .i_wrData (w_wrData),
        .i_rdAddr (r_rdPtr[AW-1:0]),
        .o_rdData (w_rdData)
    );

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, tdata width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, number of entries; power of two, >=4.
REQ-003 SHALL have parameter PACKET_MODE, default 1, meaning: 1 = store-and-forward on tlast, 0 = plain cut-through.
REQ-004 SHALL have parameter ALMOST_FULL_THR, default FIFO_DEPTH-4, level at or above which almost_full_o is high.
REQ-005 SHALL have parameter ALMOST_EMPTY_THR, default 4, level at or below which almost_empty_o is high.
REQ-006 SHALL have port clk_i, input, 1, clock; all logic on its rising edge.
REQ-007 SHALL have port arstn_i, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have ports s_axis_tdata in DATA_WIDTH, s_axis_tlast in 1, s_axis_tvalid in 1, s_axis_tready out 1, meaning the AXI-Stream slave.
REQ-009 SHALL have ports m_axis_tdata out DATA_WIDTH, m_axis_tlast out 1, m_axis_tvalid out 1, m_axis_tready in 1, meaning the AXI-Stream master.
REQ-010 SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1, meaning the stored entry count.
REQ-011 SHALL have port almost_full_o, output, 1, meaning level_o >= ALMOST_FULL_THR.
REQ-012 SHALL have port almost_empty_o, output, 1, meaning level_o <= ALMOST_EMPTY_THR.
REQ-013 SHALL have port pkt_cnt_o, output, $clog2(FIFO_DEPTH)+1, meaning the number of complete packets stored.

Function
REQ-014 SHALL push on s_axis_tvalid & s_axis_tready, storing {tlast, tdata} at the write pointer.
REQ-015 SHALL pop on m_axis_tvalid & m_axis_tready, advancing the read pointer.
REQ-016 SHALL drive s_axis_tready = (level_o != FIFO_DEPTH), independent of s_axis_tvalid.
REQ-017 SHALL present m_axis_tdata/tlast from the read-pointer entry combinationally (fall-through, zero-cycle read latency); a word is poppable the cycle after its push.
REQ-018 SHALL, with PACKET_MODE=0, drive m_axis_tvalid = (level_o != 0).
REQ-019 SHALL, with PACKET_MODE=1, drive m_axis_tvalid = (level_o != 0) & ((pkt_cnt_o != 0) | release), where release is a flag set in the cycle level_o reaches FIFO_DEPTH while pkt_cnt_o == 0 (deadlock escape) and cleared on the pop of a tlast word.
REQ-020 SHALL, once m_axis_tvalid is high, hold it high and hold tdata/tlast stable until the pop (AXIS stability).
REQ-021 SHALL update level_o by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-022 SHALL update pkt_cnt_o by +1 on a push with tlast, -1 on a pop with tlast, and leave it unchanged when both occur in the same cycle.
REQ-023 SHALL use pointers of $clog2(FIFO_DEPTH) bits plus one wrap bit each; wrap at FIFO_DEPTH-1 -> 0 SHALL toggle the wrap bit; full/empty SHALL be consistent with level_o.
REQ-024 SHALL accept simultaneous push and pop when full (pop frees the slot, push is permitted the next cycle only, since tready is low while full).
REQ-025 SHALL allow simultaneous push and pop when level_o == 1 without data corruption.
REQ-026 SHALL register almost_full_o and almost_empty_o from the next-state level (no combinational path from tvalid/tready).

Reset
REQ-027 SHALL, on arstn_i low, immediately clear pointers, wrap bits, level_o, pkt_cnt_o, and release; m_axis_tvalid=0, s_axis_tready=1, almost_full_o=0, almost_empty_o=1.
REQ-028 SHALL NOT reset the storage array; a reset mid-packet discards all stored data.

Structure
REQ-029 SHALL take shared constants (default thresholds, level-width helper) from package axis_pkg.
REQ-030 SHALL place storage in one sub-module, fifo_mem (synchronous write, asynchronous read, DATA_WIDTH+1 wide).

Verification
REQ-031 SHALL verify: PACKET_MODE=1, push 3 words without tlast -> m_axis_tvalid=0; push the 4th with tlast -> tvalid=1 the next cycle, pkt_cnt_o=1.
REQ-032 SHALL verify: DEPTH=8, push 8 words with no tlast -> s_axis_tready=0, level_o=8, release makes tvalid=1; drain 8 -> level_o=0.
REQ-033 SHALL verify: continuous push/pop with tready=1 for 200 words (DEPTH=8, 25 wraps) -> output order equals input order, level_o constant.
REQ-034 SHALL verify: at level 1 a pop of a tlast word and a push of a tlast word in the same cycle -> pkt_cnt_o and level_o unchanged.
REQ-035 SHALL verify: ALMOST_FULL_THR=6, DEPTH=8, fill to 6 -> almost_full_o=1 the cycle after the 6th push; pop 1 -> 0.
REQ-036 SHALL verify: assert arstn_i mid-packet at level 5 -> all outputs take REQ-027 values immediately; a new packet afterwards passes intact.
